// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared widths and the queued write-back entry type for the register-file write controller.
package reg_writeback_ctrl_pkg;
   localparam int DW       = 16;
   localparam int AW       = 3;
   localparam int NUM_REGS = 1 << AW;
   localparam int WB_DEPTH = 4;

   typedef struct packed {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Result-push channels, register-file write port, scoreboard and bypass lookup bundle.
interface reg_writeback_ctrl_if;
   import reg_writeback_ctrl_pkg::*;

   logic                ld_valid;
   logic [AW-1:0]       ld_rd;
   logic [DW-1:0]       ld_data;
   logic                ld_ready;
   logic                alu_valid;
   logic [AW-1:0]       alu_rd;
   logic [DW-1:0]       alu_data;
   logic                alu_ready;
   logic                we;
   logic [AW-1:0]       waddr;
   logic [DW-1:0]       wdata;
   logic [NUM_REGS-1:0] pending;
   logic [AW-1:0]       raddr1;
   logic [AW-1:0]       raddr2;
   logic                fwd1_hit;
   logic [DW-1:0]       fwd1_data;
   logic                fwd2_hit;
   logic [DW-1:0]       fwd2_data;

   modport slave (
      input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, raddr1, raddr2,
      output ld_ready, alu_ready, we, waddr, wdata, pending,
             fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
   );

   modport master (
      output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, raddr1, raddr2,
      input  ld_ready, alu_ready, we, waddr, wdata, pending,
             fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
   );
endinterface

// File: rtl/reg_writeback_ctrl_wb_fifo.sv
// Dual-push, single-pop circular buffer; push0 lands before push1 on the same edge.
// Exposes its contents oldest-first so the owner can scan valid entries (index < count).
module wb_fifo
   import reg_writeback_ctrl_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push0,
   input  wb_entry_t              din0,
   input  logic                   push1,
   input  wb_entry_t              din1,
   input  logic                   pop,
   output wb_entry_t              head,
   output logic [$clog2(DEPTH):0] count,
   output wb_entry_t              ordered [DEPTH]
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t     mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push0) + CW'(push1) - CW'(pop);
      end
   end

   // Storage is left unreset; only entries below count are ever observed.
   always_ff @(posedge clk) begin
      if (push0)
         mem[wr_ptr] <= din0;
      if (push1)
         mem[push0 ? wr_ptr + PW'(1) : wr_ptr] <= din1;
   end

   assign head = mem[rd_ptr];

   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         ordered[i] = mem[rd_ptr + PW'(i)];
   end
endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write controller: in-order LD/ALU merge queue, one registered write per cycle,
// pending scoreboard; bypass lookup is built only when FORWARD_EN is defined.
module reg_writeback_ctrl
   import reg_writeback_ctrl_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH
) (
   input logic                 clk,
   input logic                 rst,
   reg_writeback_ctrl_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0] count;
   wb_entry_t     head;
   wb_entry_t     ordered [DEPTH];
   logic          ld_push;
   logic          alu_push;
   logic          pop;
   logic          we_q;
   logic [AW-1:0] waddr_q;
   logic [DW-1:0] wdata_q;
   logic [NUM_REGS-1:0] pending_c;

   // Ready depends only on the registered occupancy; the ALU needs room for a same-edge load too.
   assign bus.ld_ready  = (count <= CW'(DEPTH - 1));
   assign bus.alu_ready = (count <= CW'(DEPTH - 2));
   assign ld_push  = bus.ld_valid  & bus.ld_ready;
   assign alu_push = bus.alu_valid & bus.alu_ready;
   assign pop      = (count != '0);

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push0   (ld_push),
      .din0    ('{rd: bus.ld_rd, data: bus.ld_data}),
      .push1   (alu_push),
      .din1    ('{rd: bus.alu_rd, data: bus.alu_data}),
      .pop     (pop),
      .head    (head),
      .count   (count),
      .ordered (ordered)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q <= pop;
         if (pop) begin
            waddr_q <= head.rd;
            wdata_q <= head.data;
         end
      end
   end

   assign bus.we    = we_q;
   assign bus.waddr = waddr_q;
   assign bus.wdata = wdata_q;

   always_comb begin
      pending_c = '0;
      for (int i = 0; i < DEPTH; i++)
         if (CW'(i) < count)
            pending_c[ordered[i].rd] = 1'b1;
      if (we_q)
         pending_c[waddr_q] = 1'b1;
   end

   assign bus.pending = pending_c;

`ifdef FORWARD_EN
   logic [AW-1:0] raddr [2];
   logic [DW-1:0] fdata [2];

   assign raddr[0] = bus.raddr1;
   assign raddr[1] = bus.raddr2;

   // Scan oldest to newest so the youngest matching value wins; the output stage is oldest of all.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         fdata[p] = '0;
         if (we_q && waddr_q == raddr[p])
            fdata[p] = wdata_q;
         for (int i = 0; i < DEPTH; i++)
            if (CW'(i) < count && ordered[i].rd == raddr[p])
               fdata[p] = ordered[i].data;
      end
   end

   assign bus.fwd1_hit  = pending_c[bus.raddr1];
   assign bus.fwd1_data = fdata[0];
   assign bus.fwd2_hit  = pending_c[bus.raddr2];
   assign bus.fwd2_data = fdata[1];
`else
   assign bus.fwd1_hit  = 1'b0;
   assign bus.fwd1_data = '0;
   assign bus.fwd2_hit  = 1'b0;
   assign bus.fwd2_data = '0;
`endif
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Scoreboard bench: stimulus queues expected writes, monitor checks WE/WADDR/WDATA, PENDING and bypass.
module tb_reg_writeback_ctrl;
   import reg_writeback_ctrl_pkg::*;

   localparam int D = WB_DEPTH;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reg_writeback_ctrl_if bus();

   reg_writeback_ctrl #(.DEPTH(D)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   wb_entry_t sb [$];
   int        prev_size = 0;
   int        tests = 0;
   int        fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus, driven just after the falling edge; the model accepts by its own occupancy.
   task automatic step(input logic ldv, input logic [AW-1:0] lrd, input logic [DW-1:0] ldd,
                       input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input logic r, input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
      int sz;
      @(negedge clk);
      #1;
      sz = sb.size();
      chk("ld_ready", bus.ld_ready, sz <= D - 1);
      chk("alu_ready", bus.alu_ready, sz <= D - 2);
      rst           = r;
      bus.ld_valid  = ldv & ~r;
      bus.ld_rd     = lrd;
      bus.ld_data   = ldd;
      bus.alu_valid = av & ~r;
      bus.alu_rd    = ard;
      bus.alu_data  = ad;
      bus.raddr1    = ra1;
      bus.raddr2    = ra2;
      if (r) begin
         prev_size = 0;
         sb.delete();
      end else begin
         prev_size = sz;
         if (ldv && sz <= D - 1)
            sb.push_back(wb_entry_t'{rd: lrd, data: ldd});
         if (av && sz <= D - 2)
            sb.push_back(wb_entry_t'{rd: ard, data: ad});
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         step(0, 0, 0, 0, 0, 0, 0, AW'($urandom), AW'($urandom));
   endtask

   wb_entry_t           cur;
   logic                exp_we;
   logic [NUM_REGS-1:0] pexp;

   function automatic logic [DW-1:0] newest(input logic [AW-1:0] ra);
      logic [DW-1:0] v;
      v = '0;
      if (exp_we && cur.rd == ra)
         v = cur.data;
      foreach (sb[i])
         if (sb[i].rd == ra)
            v = sb[i].data;
      return v;
   endfunction

   initial begin : monitor
      forever begin
         @(negedge clk);
         exp_we = (prev_size > 0);
         chk("we", bus.we, exp_we);
         if (exp_we && sb.size() > 0) begin
            cur = sb.pop_front();
            chk("waddr", bus.waddr, cur.rd);
            chk("wdata", bus.wdata, cur.data);
         end
         pexp = '0;
         foreach (sb[i])
            pexp[sb[i].rd] = 1'b1;
         if (exp_we)
            pexp[cur.rd] = 1'b1;
         chk("pending", bus.pending, pexp);
`ifdef FORWARD_EN
         chk("fwd1_hit", bus.fwd1_hit, pexp[bus.raddr1]);
         chk("fwd2_hit", bus.fwd2_hit, pexp[bus.raddr2]);
         if (pexp[bus.raddr1])
            chk("fwd1_data", bus.fwd1_data, newest(bus.raddr1));
         if (pexp[bus.raddr2])
            chk("fwd2_data", bus.fwd2_data, newest(bus.raddr2));
`else
         chk("fwd1_hit", bus.fwd1_hit, 0);
         chk("fwd2_hit", bus.fwd2_hit, 0);
         chk("fwd1_data", bus.fwd1_data, 0);
         chk("fwd2_data", bus.fwd2_data, 0);
`endif
      end
   end

   initial begin : stimulus
      bus.ld_valid  = 1'b0;
      bus.ld_rd     = '0;
      bus.ld_data   = '0;
      bus.alu_valid = 1'b0;
      bus.alu_rd    = '0;
      bus.alu_data  = '0;
      bus.raddr1    = '0;
      bus.raddr2    = '0;

      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("rst_waddr", bus.waddr, 0);
      chk("rst_wdata", bus.wdata, 0);
      chk("rst_pending", bus.pending, 0);
      idle(5);

      // Single ALU write to r2.
      step(0, 0, 0, 1, 3'd2, 16'h0625, 0, 3'd2, 3'd0);
      idle(3);

      // Same-edge load then ALU to r3; ALU value is younger.
      step(1, 3'd3, 16'h00CB, 1, 3'd3, 16'h1111, 0, 3'd3, 3'd3);
      step(0, 0, 0, 0, 0, 0, 0, 3'd3, 3'd1);
      idle(3);

      // Fill: both channels held valid.
      for (int k = 0; k < 10; k++)
         step(1, AW'(k), DW'(16'hA000 + k), 1, AW'(k + 4), DW'(16'hB000 + k), 0, AW'(k), AW'(k + 4));
      idle(6);

      // Reset with three entries queued.
      step(1, 3'd5, 16'h5555, 1, 3'd6, 16'h6666, 0, 3'd5, 3'd6);
      step(1, 3'd7, 16'h7777, 1, 3'd1, 16'h1234, 0, 3'd7, 3'd1);
      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(3);

      // r0..r7 written with zero over eight cycles.
      for (int k = 0; k < 8; k++)
         step(0, 0, 0, 1, AW'(k), 16'h0000, 0, AW'(k), AW'(7 - k));
      idle(4);

      for (int k = 0; k < 400; k++)
         step($urandom_range(0, 3) != 0, AW'($urandom), DW'($urandom),
              $urandom_range(0, 3) != 0, AW'($urandom), DW'($urandom),
              $urandom_range(0, 49) == 0, AW'($urandom), AW'($urandom));
      idle(8);

      chk("drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
